// File: rtl/serial_add_sequencer.sv
// Bit-serial adder controller.
// Adds two WIDTH-bit operands one bit per clock, LSB first, through a single
// full adder. A valid/ready handshake accepts jobs and another hands back the
// sum together with the carry-out and signed-overflow flags.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             busy
);

    localparam int            CW          = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT    = CW'(WIDTH - 1);
    localparam logic [CW-1:0] MSB_CIN_BIT = CW'(WIDTH - 2);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic             msb_cin;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    bit_cnt_inc;
    logic             fa_sum;
    logic             fa_cout;

    // Handshake and status flags decode straight from the state register.
    assign start_ready  = (state == ST_IDLE);
    assign busy         = (state == ST_RUN);
    assign result_valid = (state == ST_DONE);

    // The block's one and only full adder: current LSBs plus the carry flop.
    always_comb begin
        fa_sum  = a_sh[0] ^ b_sh[0] ^ carry;
        fa_cout = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    end

    // Bit counter increment as a ripple of half adders, so no word adder is built.
    always_comb begin
        logic ripple;
        bit_cnt_inc = '0;
        ripple      = 1'b1;
        for (int i = 0; i < CW; i++) begin
            bit_cnt_inc[i] = bit_cnt[i] ^ ripple;
            ripple         = ripple & bit_cnt[i];
        end
    end

    // Sequencer: accept, shift one bit per cycle, publish the result, then wait for the consumer.
    // Sum bits enter at the top of a_sh as its operand bits leave at the bottom, so after
    // the last bit a_sh (plus the final adder output) holds the whole sum. The visible
    // sum only changes on the final edge, keeping outputs stable while a job runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            carry    <= 1'b0;
            msb_cin  <= 1'b0;
            bit_cnt  <= '0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else if (clear) begin
            state    <= ST_IDLE;
            carry    <= 1'b0;
            msb_cin  <= 1'b0;
            bit_cnt  <= '0;
            sum      <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_valid) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry   <= carryin;
                        bit_cnt <= '0;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh    <= {fa_sum, a_sh[WIDTH-1:1]};
                    b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
                    carry   <= fa_cout;
                    bit_cnt <= bit_cnt_inc;
                    if (bit_cnt == MSB_CIN_BIT) begin
                        msb_cin <= fa_cout;
                    end
                    if (bit_cnt == LAST_BIT) begin
                        sum      <= {fa_sum, a_sh[WIDTH-1:1]};
                        carryout <= fa_cout;
                        overflow <= msb_cin ^ fa_cout;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
